seg7_scoreboard: RTL and testbench
==================================

// Module: seg7_scoreboard
// PURPOSE
// - Downstream consumer of the river-crossing game core (canoe_position, gameState).
// - Counts canoe crossings and elapsed play seconds as 2-digit BCD values.
// - Drives the 8-digit multiplexed 7-segment display: moves, time, and PASS/FAIL on game end.
// PARAMETERS
// - MAX_BCD  99  saturation value for both counters (two BCD digits)
// - DIGITS   8   digit-select width; one digit is scanned per clock
// PORTS
// - clk_1kHz        in   1  system clock; all logic in this domain
// - rst             in   1  asynchronous reset, active-high
// - clk_1Hz         in   1  1 Hz square wave from the divider; rising edge = one second
// - canoe_position  in   1  canoe bank; every toggle = one crossing
// - gameState       in   2  0 = lose, 1 = win, 2 = continue, 3 = treated as continue
// - seg             out  8  segments: [6:0] = g..a, [7] = dp, active-high
// - sel             out  8  digit select, active-low one-hot; sel[0] = rightmost digit
// - game_over       out  1  high in WIN or LOSE
// - moves_bcd       out  8  move count in BCD (tens in [7:4])
// BEHAVIOUR
// - Reset: state = PLAY, counters = 8'h00, sel = 8'hFE, seg = 8'h00, game_over = 0.
// - Edge detection: clk_1Hz and canoe_position are registered once.
//   - A rising edge (1Hz) or a toggle (canoe) is detected one cycle after the input changes.
//   - The counter shows the new value on the following clock.
// - FSM:
//   - PLAY -> WIN when gameState == 1; PLAY -> LOSE when gameState == 0.
//   - WIN/LOSE -> PLAY when gameState is 2 or 3; both counters clear on that entry.
//   - WIN <-> LOSE direct switch when gameState changes between 0 and 1.
// - Counters:
//   - Increment only in PLAY.
//   - BCD arithmetic: units wrap 9 -> 0 with a carry into tens.
//   - Saturate at MAX_BCD and hold there; they never wrap to 00.
// - Simultaneous events:
//   - Canoe toggle detected in the same cycle PLAY exits: the move IS counted (final crossing counts).
//   - 1Hz edge in the same cycle PLAY exits: NOT counted.
//   - Both edges in one cycle in PLAY: both counters increment.
// - Scan:
//   - sel rotates left by one digit every clock: FE, FD, ... 7F, FE.
//   - Full refresh is 125 Hz.
//   - seg is registered and always matches the sel digit of the same cycle.
// - Digit map (7..0):
//   - Digits 7,6: moves tens/units.
//   - Digits 5,4: blank.
//   - PLAY: digits 3,2 blank; digits 1,0 = seconds tens/units.
//   - WIN: digits 3..0 = P A S S.
//   - LOSE: digits 3..0 = F A I L.
// - Encodings (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   P=73 A=77 S=6D F=71 I=06 L=38 blank=00; dp is always 0.
// - Leading zeros are displayed (05 shows as "05").
// - Reset asserted mid-scan: sel returns to FE immediately (async) and all counts clear.
// CONFIGURATION
// - SEG7_BLINK_EN defined: in WIN/LOSE, seg is forced to 8'h00 while the registered clk_1Hz is low.
//   Sel keeps scanning; result text blinks at 1 Hz; PLAY display is unaffected.
// - SEG7_BLINK_EN undefined: result display is steady; no clk_1Hz dependence outside PLAY.
// TESTING
// - Reset release, gameState = 2, 3 clk_1Hz rising edges
//   -> time = 03, moves = 00, sel sequence FE, FD, FB after reset.
// - 12 canoe_position toggles in PLAY
//   -> moves_bcd = 8'h12; digits 7,6 show 06,5B.
// - 120 canoe toggles and 150 seconds
//   -> moves_bcd = 8'h99, time = 99, no wrap to 00.
// - Canoe toggle in the same cycle gameState becomes 1
//   -> moves incremented once, game_over = 1, digits 3..0 = 73,77,6D,6D.
// - LOSE (gameState = 0), then gameState = 2
//   -> digits show FAIL (71,77,06,38); on the return to PLAY moves = 00, time = 00, game_over = 0.
// - SEG7_BLINK_EN defined, in WIN with clk_1Hz low
//   -> seg = 00 every digit; with clk_1Hz high -> PASS shown.

Source files
------------

// File: rtl/seg7_scoreboard.sv
// Scoreboard for the river-crossing game: BCD move/second counters and 8-digit scanned display.
// Optional build macro SEG7_BLINK_EN blinks the PASS/FAIL text at 1 Hz.
module seg7_scoreboard #(
  parameter logic [7:0] MAX_BCD = 8'h99,
  parameter int         DIGITS  = 8
) (
  input  logic              clk_1kHz,
  input  logic              rst,
  input  logic              clk_1Hz,
  input  logic              canoe_position,
  input  logic [1:0]        gameState,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] sel,
  output logic              game_over,
  output logic [7:0]        moves_bcd
);

  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;

  state_t            state_q, state_d;
  logic              c1hz_q, c1hz_d;
  logic              canoe_q, canoe_d;
  logic [7:0]        moves_q, moves_d;
  logic [7:0]        secs_q, secs_d;
  logic [IDX_W-1:0]  dig_q, dig_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              sec_tick, move_tick;
  logic [6:0]        glyph;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == MAX_BCD)      return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7_num(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign c1hz_d    = clk_1Hz;
  assign canoe_d   = canoe_position;
  assign sec_tick  = clk_1Hz & ~c1hz_q;
  assign move_tick = canoe_position ^ canoe_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY: begin
        if (gameState == 2'd1)      state_d = WIN;
        else if (gameState == 2'd0) state_d = LOSE;
      end
      WIN: begin
        if (gameState == 2'd0)      state_d = LOSE;
        else if (gameState[1])      state_d = PLAY;
      end
      LOSE: begin
        if (gameState == 2'd1)      state_d = WIN;
        else if (gameState[1])      state_d = PLAY;
      end
      default:                      state_d = PLAY;
    endcase
  end

  // The final crossing counts even as play ends; a second tick on the exit cycle does not.
  always_comb begin
    moves_d = moves_q;
    secs_d  = secs_q;
    if (state_q != PLAY && state_d == PLAY) begin
      moves_d = 8'h00;
      secs_d  = 8'h00;
    end else if (state_q == PLAY) begin
      if (move_tick)                     moves_d = bcd_inc(moves_q);
      if (sec_tick && state_d == PLAY)   secs_d  = bcd_inc(secs_q);
    end
  end

  // seg is built from next-cycle values so it lines up with the sel it is registered beside.
  always_comb begin
    dig_d = (dig_q == IDX_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    sel_d = ~(DIGITS'(1) << dig_d);
    glyph = 7'h00;
    case (int'(dig_d))
      7: glyph = seg7_num(moves_d[7:4]);
      6: glyph = seg7_num(moves_d[3:0]);
      3: glyph = (state_d == WIN) ? 7'h73 : (state_d == LOSE) ? 7'h71 : 7'h00;
      2: glyph = (state_d == PLAY) ? 7'h00 : 7'h77;
      1: glyph = (state_d == WIN) ? 7'h6D : (state_d == LOSE) ? 7'h06 : seg7_num(secs_d[7:4]);
      0: glyph = (state_d == WIN) ? 7'h6D : (state_d == LOSE) ? 7'h38 : seg7_num(secs_d[3:0]);
      default: glyph = 7'h00;
    endcase
    seg_d = {1'b0, glyph};
`ifdef SEG7_BLINK_EN
    if (state_d != PLAY && !c1hz_d) seg_d = 8'h00;
`else
    seg_d = {1'b0, glyph};
`endif
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      state_q <= PLAY;
      c1hz_q  <= 1'b0;
      canoe_q <= 1'b0;
      moves_q <= 8'h00;
      secs_q  <= 8'h00;
      dig_q   <= '0;
      sel_q   <= ~DIGITS'(1);
      seg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      c1hz_q  <= c1hz_d;
      canoe_q <= canoe_d;
      moves_q <= moves_d;
      secs_q  <= secs_d;
      dig_q   <= dig_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign sel       = sel_q;
  assign game_over = (state_q != PLAY);
  assign moves_bcd = moves_q;

endmodule

// File: tb/tb_seg7_scoreboard.sv
// Directed and randomized bench for seg7_scoreboard against a decimal game/score model.
module tb_seg7_scoreboard;

  logic       clk_1kHz = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       canoe_position = 1'b0;
  logic [1:0] gameState = 2'd2;
  logic [7:0] seg;
  logic [7:0] sel;
  logic       game_over;
  logic [7:0] moves_bcd;

  int checks = 0;
  int errors = 0;

  // Model: plain decimal counts and a game phase (0 play, 1 win, 2 lose)
  int m_moves = 0;
  int m_secs  = 0;
  int m_state = 0;

  logic [7:0] got [8];
  logic [6:0] num_glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scoreboard dut (
    .clk_1kHz       (clk_1kHz),
    .rst            (rst),
    .clk_1Hz        (clk_1Hz),
    .canoe_position (canoe_position),
    .gameState      (gameState),
    .seg            (seg),
    .sel            (sel),
    .game_over      (game_over),
    .moves_bcd      (moves_bcd)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic logic [7:0] exp_digit(input int d, input logic hz);
    logic [7:0] r;
    r = 8'h00;
    case (d)
      7: r = {1'b0, num_glyph[m_moves / 10]};
      6: r = {1'b0, num_glyph[m_moves % 10]};
      3: r = (m_state == 1) ? 8'h73 : (m_state == 2) ? 8'h71 : 8'h00;
      2: r = (m_state == 0) ? 8'h00 : 8'h77;
      1: r = (m_state == 1) ? 8'h6D : (m_state == 2) ? 8'h06 : {1'b0, num_glyph[m_secs / 10]};
      0: r = (m_state == 1) ? 8'h6D : (m_state == 2) ? 8'h38 : {1'b0, num_glyph[m_secs % 10]};
      default: r = 8'h00;
    endcase
`ifdef SEG7_BLINK_EN
    if (m_state != 0 && !hz) r = 8'h00;
`endif
    return r;
  endfunction

  task automatic read_display();
    for (int i = 0; i < 8; i++) got[i] = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_1kHz);
      for (int b = 0; b < 8; b++)
        if (!sel[b]) got[b] = seg;
    end
  endtask

  task automatic check_display(input string tag);
    read_display();
    for (int d = 0; d < 8; d++)
      check($sformatf("%s_dig%0d", tag, d), got[d], exp_digit(d, clk_1Hz));
  endtask

  task automatic toggle_canoe();
    canoe_position = ~canoe_position;
    repeat (2) @(negedge clk_1kHz);
    if (m_state == 0 && m_moves < 99) m_moves++;
  endtask

  task automatic pulse_sec(input bit with_move);
    clk_1Hz = 1'b1;
    if (with_move) canoe_position = ~canoe_position;
    repeat (2) @(negedge clk_1kHz);
    clk_1Hz = 1'b0;
    repeat (2) @(negedge clk_1kHz);
    if (m_state == 0 && m_secs < 99) m_secs++;
    if (with_move && m_state == 0 && m_moves < 99) m_moves++;
  endtask

  task automatic set_gs(input logic [1:0] v);
    gameState = v;
    repeat (2) @(negedge clk_1kHz);
    if (v == 2'd1) m_state = 1;
    else if (v == 2'd0) m_state = 2;
    else if (m_state != 0) begin
      m_state = 0; m_moves = 0; m_secs = 0;
    end
  endtask

  task automatic check_result();
    check_display($sformatf("res%0d_hzlo", m_state));
    clk_1Hz = 1'b1;
    check_display($sformatf("res%0d_hzhi", m_state));
    clk_1Hz = 1'b0;
    @(negedge clk_1kHz);
  endtask

  initial begin
    // Reset held across a clock edge
    repeat (2) @(negedge clk_1kHz);
    check("rst_sel", sel, 8'hFE);
    check("rst_seg", seg, 8'h00);
    check("rst_game_over", {7'b0, game_over}, 8'h00);
    check("rst_moves", moves_bcd, 8'h00);
    rst = 1'b0;
    check("scan0", sel, 8'hFE);
    @(negedge clk_1kHz);
    check("scan1", sel, 8'hFD);
    @(negedge clk_1kHz);
    check("scan2", sel, 8'hFB);

    // Three seconds of play, no crossings
    repeat (3) pulse_sec(1'b0);
    check("t3_moves", moves_bcd, to_bcd(m_moves));
    check_display("t3");

    // Twelve crossings
    repeat (12) toggle_canoe();
    check("m12_moves", moves_bcd, 8'h12);
    check_display("m12");

    // Saturation of both counters
    repeat (120) toggle_canoe();
    repeat (150) pulse_sec(1'b0);
    check("sat_moves", moves_bcd, 8'h99);
    check_display("sat");

    // LOSE, then back to PLAY clears everything
    set_gs(2'd0);
    check("lose_game_over", {7'b0, game_over}, 8'h01);
    check("lose_moves", moves_bcd, 8'h99);
    check_result();
    set_gs(2'd2);
    check("replay_game_over", {7'b0, game_over}, 8'h00);
    check("replay_moves", moves_bcd, 8'h00);
    check_display("replay");

    // Randomized play: crossings, seconds, and both in one cycle
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: toggle_canoe();
        1: pulse_sec(1'b0);
        default: pulse_sec(1'b1);
      endcase
    end
    check("rand_moves", moves_bcd, to_bcd(m_moves));
    check_display("rand");

    // Final crossing on the same cycle play ends in a win
    canoe_position = ~canoe_position;
    gameState = 2'd1;
    repeat (2) @(negedge clk_1kHz);
    if (m_moves < 99) m_moves++;
    m_state = 1;
    check("win_game_over", {7'b0, game_over}, 8'h01);
    check("win_moves", moves_bcd, to_bcd(m_moves));
    check_result();

    // Direct WIN -> LOSE, then state 3 returns to PLAY
    set_gs(2'd0);
    check("w2l_moves", moves_bcd, to_bcd(m_moves));
    check_result();
    set_gs(2'd3);
    check("gs3_game_over", {7'b0, game_over}, 8'h00);
    check_display("gs3");

    // Asynchronous reset in the middle of a scan
    repeat (5) toggle_canoe();
    repeat (3) @(negedge clk_1kHz);
    #2 rst = 1'b1;
    #1;
    check("arst_sel", sel, 8'hFE);
    check("arst_moves", moves_bcd, 8'h00);
    check("arst_seg", seg, 8'h00);
    @(negedge clk_1kHz);
    rst = 1'b0;
    m_moves = 0; m_secs = 0; m_state = 0;
    check_display("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
